// File: rtl/core_fetch_sequencer_pkg.sv
// core_fetch_sequencer_pkg: shared types and defaults for the core fetch sequencer.
// No ports; provides the FSM state encoding and the default fetch stride.
package core_fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } seq_state_e;

  localparam int DEF_ADDR_STEP = 4;

endpackage

// File: rtl/core_fetch_sequencer_if.sv
// core_fetch_sequencer_if: IMEM read bus and decoder instruction bus.
// master = sequencer side (IMEM_REQ/ADDR, INST_* out); slave = memory/decoder.
interface core_fetch_sequencer_if #(
  parameter int AW = 32,
  parameter int DW = 32
);

  logic          IMEM_REQ;
  logic [AW-1:0] IMEM_ADDR;
  logic          IMEM_GNT;
  logic          IMEM_RVALID;
  logic [DW-1:0] IMEM_RDATA;
  logic          INST_VALID;
  logic [DW-1:0] INST_DATA;
  logic [AW-1:0] INST_PC;
  logic          INST_READY;

  modport master (
    output IMEM_REQ, IMEM_ADDR,
    input  IMEM_GNT, IMEM_RVALID, IMEM_RDATA,
    output INST_VALID, INST_DATA, INST_PC,
    input  INST_READY
  );

  modport slave (
    input  IMEM_REQ, IMEM_ADDR,
    output IMEM_GNT, IMEM_RVALID, IMEM_RDATA,
    input  INST_VALID, INST_DATA, INST_PC,
    output INST_READY
  );

endinterface

// File: rtl/core_fetch_sequencer_fifo.sv
// core_fetch_sequencer_fifo: synchronous FIFO with flush; head read from flops.
// Ports: clk, rst, push/wdata, pop, flush in; rdata, full, empty, count out.
module core_fetch_sequencer_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  input  logic          flush,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  // Pop on empty is ignored; push on full only with a same-cycle pop.
  always_comb begin
    do_pop  = pop && (cnt_q != '0);
    do_push = push && ((cnt_q != CW'(DEPTH)) || do_pop);
    rd_d    = rd_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    if (flush) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      if (do_push && !flush) mem_q[wr_q] <= wdata;
    end
  end

  assign rdata = mem_q[rd_q];
  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));
  assign count = cnt_q;

endmodule

// File: rtl/core_fetch_sequencer.sv
// core_fetch_sequencer: fetches instruction words from IMEM starting at CMEM_ADDR
// and buffers them for the decoder. Ports: CCLK, CRST, CEXEC, CMEM_ADDR, CSTAT,
// bus (IMEM/INST master), CORE_JUMP, CORE_JUMP_ADDR, CORE_HALT.
module core_fetch_sequencer
  import core_fetch_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int FIFO_DEPTH      = 4,
  parameter int MAX_OUTSTANDING = 2,
  parameter int ADDR_STEP       = DEF_ADDR_STEP
) (
  input  logic                  CCLK,
  input  logic                  CRST,
  input  logic                  CEXEC,
  input  logic [ADDR_WIDTH-1:0] CMEM_ADDR,
  output logic                  CSTAT,
  core_fetch_sequencer_if.master bus,
  input  logic                  CORE_JUMP,
  input  logic [ADDR_WIDTH-1:0] CORE_JUMP_ADDR,
  input  logic                  CORE_HALT
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int FW = ADDR_WIDTH + DATA_WIDTH;

  seq_state_e            state_q, state_d;
  logic                  cexec_q;
  logic                  cstat_q, cstat_d;
  logic                  bubble_q, bubble_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] rpc_q, rpc_d;
  logic [CW-1:0]         infl_q, infl_d;
  logic [CW-1:0]         drop_q, drop_d;

  logic          gnt, rv, rv_drop;
  logic          start, halt, jump, flush;
  logic          push, full, empty;
  logic [CW-1:0] count;
  logic [CW:0]   used;
  logic [FW-1:0] head;

  // Requests are issued only while buffer space covers every granted read.
  always_comb begin
    used = {1'b0, count} + {1'b0, infl_q};
    bus.IMEM_REQ = (state_q == RUN) && !bubble_q
                && (used < (CW+1)'(FIFO_DEPTH))
                && (infl_q < CW'(MAX_OUTSTANDING));
  end

  always_comb begin
    gnt     = bus.IMEM_REQ && bus.IMEM_GNT;
    rv      = bus.IMEM_RVALID && (infl_q != '0);
    rv_drop = rv && (drop_q != '0);
    start   = (state_q == IDLE) && CEXEC && !cexec_q;
    halt    = (state_q == RUN) && CORE_HALT;
    jump    = (state_q == RUN) && CORE_JUMP && !CORE_HALT;
    flush   = halt || jump;
    push    = rv && !rv_drop && (state_q == RUN) && !flush;

    infl_d = infl_q + CW'(gnt) - CW'(rv);
    // After a redirect every read still outstanding is stale.
    drop_d = flush ? infl_d : drop_q - CW'(rv_drop);

    pc_d = pc_q;
    if (start)     pc_d = CMEM_ADDR;
    else if (jump) pc_d = CORE_JUMP_ADDR;
    else if (gnt)  pc_d = pc_q + ADDR_WIDTH'(ADDR_STEP);

    // PC of the next response that will be kept.
    rpc_d = rpc_q;
    if (start)     rpc_d = CMEM_ADDR;
    else if (jump) rpc_d = CORE_JUMP_ADDR;
    else if (push) rpc_d = rpc_q + ADDR_WIDTH'(ADDR_STEP);

    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (halt) state_d = DRAIN;
      DRAIN:   if (infl_d == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    cstat_d  = (state_d != IDLE);
    bubble_d = jump;
  end

  always_ff @(posedge CCLK) begin
    if (CRST) begin
      state_q  <= IDLE;
      cexec_q  <= 1'b1;
      cstat_q  <= 1'b0;
      bubble_q <= 1'b0;
      pc_q     <= '0;
      rpc_q    <= '0;
      infl_q   <= '0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      cexec_q  <= CEXEC;
      cstat_q  <= cstat_d;
      bubble_q <= bubble_d;
      pc_q     <= pc_d;
      rpc_q    <= rpc_d;
      infl_q   <= infl_d;
      drop_q   <= drop_d;
    end
  end

  core_fetch_sequencer_fifo #(
    .W     (FW),
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk   (CCLK),
    .rst   (CRST),
    .push  (push),
    .wdata ({bus.IMEM_RDATA, rpc_q}),
    .pop   (bus.INST_READY),
    .flush (flush),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  a_no_overflow: assert property (
    @(posedge CCLK) disable iff (CRST)
    !(push && full && !bus.INST_READY)
  );

  assign CSTAT         = cstat_q;
  assign bus.IMEM_ADDR = pc_q;
  assign bus.INST_VALID = !empty;
  assign bus.INST_DATA = head[FW-1:ADDR_WIDTH];
  assign bus.INST_PC   = head[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_core_fetch_sequencer.sv
// tb_core_fetch_sequencer: IMEM model plus decoder scoreboard for the
// fetch sequencer; directed run/stall/jump/halt/wrap/reset scenarios.
module tb_core_fetch_sequencer;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cexec = 1'b0;
  logic          jump = 1'b0;
  logic          halt = 1'b0;
  logic [AW-1:0] cmem_addr = '0;
  logic [AW-1:0] jump_addr = '0;
  logic          cstat;

  int n_checks = 0;
  int n_fail   = 0;
  int n_gnt    = 0;
  int n_pop    = 0;
  int gnt_budget = 1000000;
  bit hold_rv  = 1'b0;
  logic [AW-1:0] last_pc = '0;

  logic [AW-1:0] pend_q [$];
  logic [AW-1:0] gaddr_q [$];
  logic [63:0]   exp_q [$];

  core_fetch_sequencer_if #(.AW(AW), .DW(DW)) bus ();

  core_fetch_sequencer #(
    .ADDR_WIDTH      (AW),
    .DATA_WIDTH      (DW),
    .FIFO_DEPTH      (4),
    .MAX_OUTSTANDING (2),
    .ADDR_STEP       (4)
  ) dut (
    .CCLK           (clk),
    .CRST           (rst),
    .CEXEC          (cexec),
    .CMEM_ADDR      (cmem_addr),
    .CSTAT          (cstat),
    .bus            (bus),
    .CORE_JUMP      (jump),
    .CORE_JUMP_ADDR (jump_addr),
    .CORE_HALT      (halt)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mdata(logic [AW-1:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_1234;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Runs on the falling edge: checks decoder pops, drives IMEM responses.
  task automatic model_step();
    logic [63:0]   e;
    logic [AW-1:0] a;
    if (!rst && bus.INST_VALID && bus.INST_READY) begin
      chk("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("inst_pc", 64'(bus.INST_PC), 64'(e[31:0]));
        chk("inst_data", 64'(bus.INST_DATA), 64'(e[63:32]));
      end
      n_pop++;
      last_pc = bus.INST_PC;
    end
    bus.IMEM_RVALID = 1'b0;
    bus.IMEM_GNT    = 1'b0;
    if (rst) begin
      pend_q.delete();
      exp_q.delete();
    end else begin
      if (!hold_rv && pend_q.size() != 0) begin
        a = pend_q.pop_front();
        bus.IMEM_RVALID = 1'b1;
        bus.IMEM_RDATA  = mdata(a);
      end
      if (jump || halt) exp_q.delete();
      bus.IMEM_GNT = (gnt_budget > 0);
      if (bus.IMEM_REQ && bus.IMEM_GNT) begin
        a = bus.IMEM_ADDR;
        pend_q.push_back(a);
        gaddr_q.push_back(a);
        n_gnt++;
        gnt_budget--;
        if (!(jump || halt)) exp_q.push_back({mdata(a), a});
      end
    end
  endtask

  task automatic tick(int n = 1);
    repeat (n) begin
      @(negedge clk);
      model_step();
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_run(logic [AW-1:0] addr);
    cmem_addr = addr;
    cexec = 1'b1;
    tick();
    cexec = 1'b0;
  endtask

  task automatic halt_run();
    bus.INST_READY = 1'b0;
    gnt_budget = 1000000;
    hold_rv = 1'b0;
    tick();
    halt = 1'b1;
    tick();
    halt = 1'b0;
    for (int i = 0; i < 50 && cstat; i++) tick();
    chk("halt_idle", 64'(cstat), 64'd0);
    chk("halt_ivalid", 64'(bus.INST_VALID), 64'd0);
  endtask

  initial begin
    int p0;
    int g0;
    bus.INST_READY  = 1'b0;
    bus.IMEM_GNT    = 1'b0;
    bus.IMEM_RVALID = 1'b0;
    bus.IMEM_RDATA  = '0;

    tick(3);
    chk("rst_cstat", 64'(cstat), 64'd0);
    chk("rst_req", 64'(bus.IMEM_REQ), 64'd0);
    chk("rst_ivalid", 64'(bus.INST_VALID), 64'd0);
    chk("rst_iaddr", 64'(bus.IMEM_ADDR), 64'd0);
    chk("rst_idata", 64'(bus.INST_DATA), 64'd0);
    chk("rst_ipc", 64'(bus.INST_PC), 64'd0);
    rst = 1'b0;
    tick();

    // T1: streaming fetch from 0x100
    bus.INST_READY = 1'b1;
    chk("t1_cstat_pre", 64'(cstat), 64'd0);
    start_run(32'h100);
    chk("t1_cstat", 64'(cstat), 64'd1);
    chk("t1_req", 64'(bus.IMEM_REQ), 64'd1);
    chk("t1_addr", 64'(bus.IMEM_ADDR), 64'h100);
    p0 = n_pop;
    tick(20);
    chk("t1_progress", 64'(n_pop - p0 >= 10), 64'd1);
    halt_run();

    // T2: decoder stalled, buffer fills to depth
    bus.INST_READY = 1'b0;
    g0 = n_gnt;
    p0 = n_pop;
    start_run(32'h400);
    tick(15);
    chk("t2_grants", 64'(n_gnt - g0), 64'd4);
    chk("t2_req", 64'(bus.IMEM_REQ), 64'd0);
    chk("t2_ivalid", 64'(bus.INST_VALID), 64'd1);
    chk("t2_head_pc", 64'(bus.INST_PC), 64'h400);
    bus.INST_READY = 1'b1;
    tick(20);
    chk("t2_resume", 64'(n_pop - p0 >= 8), 64'd1);
    halt_run();

    // T3: jump with two reads in flight
    bus.INST_READY = 1'b0;
    gnt_budget = 2;
    hold_rv = 1'b1;
    start_run(32'h180);
    tick(4);
    chk("t3_req_cap", 64'(bus.IMEM_REQ), 64'd0);
    jump_addr = 32'h200;
    jump = 1'b1;
    p0 = n_pop;
    tick();
    jump = 1'b0;
    gnt_budget = 1000000;
    hold_rv = 1'b0;
    bus.INST_READY = 1'b1;
    for (int i = 0; i < 40 && n_pop == p0; i++) tick();
    chk("t3_pop_seen", 64'(n_pop != p0), 64'd1);
    chk("t3_first_pc", 64'(last_pc), 64'h200);
    tick(8);
    halt_run();

    // T4: halt with one read in flight, then restart
    bus.INST_READY = 1'b1;
    gnt_budget = 1;
    hold_rv = 1'b1;
    start_run(32'h500);
    tick(3);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    chk("t4_req_off", 64'(bus.IMEM_REQ), 64'd0);
    chk("t4_cstat_hold", 64'(cstat), 64'd1);
    tick(3);
    chk("t4_cstat_wait", 64'(cstat), 64'd1);
    hold_rv = 1'b0;
    tick();
    chk("t4_cstat_off", 64'(cstat), 64'd0);
    chk("t4_ivalid", 64'(bus.INST_VALID), 64'd0);
    gnt_budget = 1000000;
    start_run(32'h600);
    chk("t4_restart", 64'(cstat), 64'd1);
    tick(10);
    halt_run();

    // T5: address wrap
    bus.INST_READY = 1'b1;
    g0 = gaddr_q.size();
    start_run(32'hFFFF_FFFC);
    tick(10);
    chk("t5_ngnt", 64'(gaddr_q.size() - g0 >= 2), 64'd1);
    if (gaddr_q.size() - g0 >= 2) begin
      chk("t5_addr0", 64'(gaddr_q[g0]), 64'hFFFF_FFFC);
      chk("t5_addr1", 64'(gaddr_q[g0+1]), 64'h0);
    end
    halt_run();

    // T6: reset mid-run with buffer half full
    bus.INST_READY = 1'b0;
    gnt_budget = 2;
    start_run(32'h700);
    tick(6);
    chk("t6_half", 64'(bus.INST_VALID), 64'd1);
    cexec = 1'b1;
    rst = 1'b1;
    tick();
    chk("t6_cstat", 64'(cstat), 64'd0);
    chk("t6_req", 64'(bus.IMEM_REQ), 64'd0);
    chk("t6_ivalid", 64'(bus.INST_VALID), 64'd0);
    rst = 1'b0;
    g0 = n_gnt;
    gnt_budget = 1000000;
    tick(5);
    chk("t6_norestart", 64'(cstat), 64'd0);
    chk("t6_nogrant", 64'(n_gnt - g0), 64'd0);
    cexec = 1'b0;
    tick();
    bus.INST_READY = 1'b1;
    start_run(32'h800);
    chk("t6_restart", 64'(cstat), 64'd1);
    tick(10);
    halt_run();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
